fp_stream_accumulator: RTL and testbench

- Sequential front/back end for the team's combinational IEEE-754 single-precision adder.
- Accepts a packet of FP32 operands over a valid/ready stream and drives the adder's a/b inputs: a = running sum, b = next operand.
- Captures the adder result back into the accumulator.
- At packet end, presents the sum and the element count on a valid/ready output stream.

---
 rtl/fp_stream_accumulator.sv | 141 ++++++++++++++
 tb/tb_fp_stream_accumulator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator: stream front/back end around an external combinational
// FP32 adder. Operands of a packet are folded into a running sum one at a time
// (add_a = running sum, add_b = next operand). The sum and the operand count are
// presented on an output stream when the packet ends. No FP arithmetic happens
// here; rounding and special values are entirely the adder's business.
module fp_stream_accumulator #(
    parameter int ADD_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int WAIT_W = (ADD_WAIT > 1) ? $clog2(ADD_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ADD_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        ADD,
        OUT
    } AccState;

    AccState state;
    AccState nextState;

    logic [31:0]       accReg;
    logic [31:0]       opndReg;
    logic [CNT_W-1:0]  countReg;
    logic [WAIT_W-1:0] waitCnt;
    logic              lastReg;

    logic inReadyInt;
    logic outValidInt;
    logic inFire;
    logic addDone;

    assign inFire  = in_valid & inReadyInt;
    assign addDone = (waitCnt == '0);

    // State register; reset drops any partially accumulated packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and handshake outputs; in_ready depends on the state alone.
    always_comb begin
        nextState   = state;
        inReadyInt  = 1'b0;
        outValidInt = 1'b0;
        case (state)
            IDLE: begin
                inReadyInt = 1'b1;
                if (in_valid) begin
                    nextState = in_last ? OUT : ACCEPT;
                end
            end
            ACCEPT: begin
                inReadyInt = 1'b1;
                if (in_valid) begin
                    nextState = ADD;
                end
            end
            ADD: begin
                if (addDone) begin
                    nextState = lastReg ? OUT : ACCEPT;
                end
            end
            OUT: begin
                outValidInt = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: the first operand loads the accumulator directly so odd encodings
    // survive bit-exact; later operands wait out the adder delay before capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accReg   <= 32'h0;
            opndReg  <= 32'h0;
            countReg <= '0;
            waitCnt  <= '0;
            lastReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inFire) begin
                        accReg   <= in_data;
                        countReg <= CNT_W'(1);
                    end
                end
                ACCEPT: begin
                    if (inFire) begin
                        opndReg <= in_data;
                        lastReg <= in_last;
                        waitCnt <= WAIT_LOAD;
                    end
                end
                ADD: begin
                    if (!addDone) begin
                        waitCnt <= waitCnt - WAIT_W'(1);
                    end else begin
                        accReg <= add_s;
                        if (countReg != '1) begin
                            countReg <= countReg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = inReadyInt;
    assign out_valid = outValidInt;
    assign add_a     = accReg;
    assign add_b     = opndReg;
    assign out_data  = accReg;
    assign out_count = countReg;

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// tb_fp_stream_accumulator: three accumulator builds (baseline, slow adder,
// narrow counter), each closed around a behavioural FP32 adder model. Directed
// vectors come from a table; random packets are checked against the exact sum
// of their operands and a saturating count.
module tb_fp_stream_accumulator;

    typedef struct {
        int                  inst;
        int                  n;
        logic [0:7][31:0]    ops;
        int                  maxGap;
        int                  holdOut;
        logic [31:0]         expData;
        logic [31:0]         expCount;
    } Vector;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid  [3];
    logic        inLast   [3];
    logic        outReady [3];
    logic [31:0] inData   [3];
    logic        inReady  [3];
    logic        outValid [3];
    logic [31:0] addA     [3];
    logic [31:0] addB     [3];
    logic [31:0] addS     [3];
    logic [31:0] outData  [3];
    logic [31:0] outCount [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int total = 0;
    int bad   = 0;
    Vector vecs[7];

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    fp_stream_accumulator #(.ADD_WAIT(1), .CNT_W(16)) dutBase (
        .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data(inData[0]), .in_last(inLast[0]), .add_a(addA[0]), .add_b(addB[0]),
        .add_s(addS[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_data(outData[0]), .out_count(cnt0));

    fp_stream_accumulator #(.ADD_WAIT(3), .CNT_W(16)) dutSlow (
        .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data(inData[1]), .in_last(inLast[1]), .add_a(addA[1]), .add_b(addB[1]),
        .add_s(addS[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_data(outData[1]), .out_count(cnt1));

    fp_stream_accumulator #(.ADD_WAIT(1), .CNT_W(2)) dutNarrow (
        .clk(clk), .rst_n(rstN), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_data(inData[2]), .in_last(inLast[2]), .add_a(addA[2]), .add_b(addB[2]),
        .add_s(addS[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .out_data(outData[2]), .out_count(cnt2));

    function automatic real fp32ToReal(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] realToFp32(input real r);
        real         a;
        int          e;
        int          frac;
        logic        s;
        logic [7:0]  expBits;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        frac    = int'((a - 1.0) * 8388608.0);
        expBits = 8'(e + 127);
        return {s, expBits, frac[22:0]};
    endfunction

    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        return realToFp32(fp32ToReal(a) + fp32ToReal(b));
    endfunction

    function automatic int waitOf(input int idx);
        return (idx == 1) ? 3 : 1;
    endfunction

    function automatic int satOf(input int idx);
        return (idx == 2) ? 3 : 65535;
    endfunction

    // Collect the count outputs of the differently sized builds into one view.
    always_comb begin
        outCount[0] = {16'b0, cnt0};
        outCount[1] = {16'b0, cnt1};
        outCount[2] = {30'b0, cnt2};
    end

    // Behavioural adder closing the loop for every build.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addS[i] = fpAdd(addA[i], addB[i]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input int idx);
        checkOutput($sformatf("rst%0d inReady", idx), 32'(inReady[idx]), 32'd1);
        checkOutput($sformatf("rst%0d outValid", idx), 32'(outValid[idx]), 32'd0);
        checkOutput($sformatf("rst%0d addA", idx), addA[idx], 32'h0);
        checkOutput($sformatf("rst%0d addB", idx), addB[idx], 32'h0);
        checkOutput($sformatf("rst%0d outData", idx), outData[idx], 32'h0);
        checkOutput($sformatf("rst%0d outCount", idx), outCount[idx], 32'h0);
    endtask

    // Streams one packet into build idx and checks ADD timing, operand
    // stability and the result handshake. All sampling happens at negedge.
    task automatic applyStimulus(input int idx, input int n, input logic [0:7][31:0] ops,
                                 input int maxGap, input int holdOut,
                                 input logic [31:0] expData, input logic [31:0] expCount,
                                 input string tag);
        int          sent    = 0;
        int          gap     = 0;
        int          lowRun  = 0;
        int          outSeen = 0;
        int          cycles  = 0;
        bit          finishing = 1'b0;
        bit          finished  = 1'b0;
        logic [31:0] heldA = 32'h0;
        logic [31:0] heldB = 32'h0;
        while (!finished && cycles < 500) begin
            @(negedge clk);
            cycles++;
            if (finishing) begin
                checkOutput({tag, " outValid drop"}, 32'(outValid[idx]), 32'd0);
                checkOutput({tag, " idle ready"}, 32'(inReady[idx]), 32'd1);
                outReady[idx] = 1'b0;
                finished = 1'b1;
            end else begin
                if (!inReady[idx] && !outValid[idx]) begin
                    if (lowRun == 0) begin
                        heldA = addA[idx];
                        heldB = addB[idx];
                        if (sent > 0) checkOutput({tag, " addB operand"}, addB[idx], ops[sent-1]);
                    end else begin
                        checkOutput({tag, " addA stable"}, addA[idx], heldA);
                        checkOutput({tag, " addB stable"}, addB[idx], heldB);
                    end
                    lowRun++;
                end else if (lowRun > 0) begin
                    checkOutput({tag, " ADD length"}, 32'(lowRun), 32'(waitOf(idx)));
                    lowRun = 0;
                end
                if (outValid[idx]) begin
                    checkOutput({tag, " outData"}, outData[idx], expData);
                    checkOutput({tag, " outCount"}, outCount[idx], expCount);
                    checkOutput({tag, " inReady in OUT"}, 32'(inReady[idx]), 32'd0);
                    outReady[idx] = (outSeen >= holdOut);
                    if (outSeen >= holdOut) finishing = 1'b1;
                    outSeen++;
                end
                inValid[idx] = 1'b0;
                inLast[idx]  = 1'b0;
                if (sent < n && !outValid[idx]) begin
                    if (gap > 0) begin
                        gap--;
                    end else begin
                        inValid[idx] = 1'b1;
                        inData[idx]  = ops[sent];
                        inLast[idx]  = (sent == n - 1);
                        if (inReady[idx]) begin
                            sent++;
                            gap = $urandom_range(0, maxGap);
                        end
                    end
                end
            end
        end
        if (!finished) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: got no result after %0d cycles, want one", tag, cycles);
        end
        inValid[idx]  = 1'b0;
        inLast[idx]   = 1'b0;
        outReady[idx] = 1'b0;
    endtask

    // Aborts a 3-operand packet with reset during its first ADD, then runs a
    // fresh single-operand packet.
    task automatic resetMidPacket();
        @(negedge clk);
        inValid[0] = 1'b1; inData[0] = 32'h3F800000; inLast[0] = 1'b0;
        @(negedge clk);
        inData[0] = 32'h40000000;
        @(negedge clk);
        inValid[0] = 1'b0;
        checkOutput("abort in ADD", 32'(inReady[0]), 32'd0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abort inReady", 32'(inReady[0]), 32'd1);
        checkOutput("abort outValid", 32'(outValid[0]), 32'd0);
        checkOutput("abort addA", addA[0], 32'h0);
        checkOutput("abort addB", addB[0], 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 1, {32'h40000000, 224'b0}, 0, 0, 32'h40000000, 32'd1, "after abort");
    endtask

    task automatic setVec(input int i, input int inst, input int n, input logic [0:7][31:0] ops,
                          input int maxGap, input int holdOut,
                          input logic [31:0] expData, input logic [31:0] expCount);
        vecs[i].inst     = inst;
        vecs[i].n        = n;
        vecs[i].ops      = ops;
        vecs[i].maxGap   = maxGap;
        vecs[i].holdOut  = holdOut;
        vecs[i].expData  = expData;
        vecs[i].expCount = expCount;
    endtask

    initial begin
        logic [0:7][31:0] rops;
        logic [31:0]      rexp;
        real              sum;
        int               ridx;
        int               rn;
        int               rsat;

        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid[i] = 1'b0; inLast[i] = 1'b0; outReady[i] = 1'b0; inData[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) checkResetState(i);
        rstN = 1'b1;
        @(negedge clk);

        setVec(0, 0, 3, {32'h3F800000, 32'h40000000, 32'h40400000, 160'b0}, 0, 0, 32'h40C00000, 32'd3);
        setVec(1, 0, 1, {32'h80000000, 224'b0}, 0, 5, 32'h80000000, 32'd1);
        setVec(2, 0, 2, {32'h3FC00000, 32'hBFC00000, 192'b0}, 4, 0, 32'h00000000, 32'd2);
        setVec(3, 1, 4, {{4{32'h3F800000}}, 128'b0}, 0, 0, 32'h40800000, 32'd4);
        setVec(4, 2, 5, {{5{32'h3F800000}}, 96'b0}, 0, 0, 32'h40A00000, 32'd3);
        setVec(5, 0, 1, {32'h00000001, 224'b0}, 0, 1, 32'h00000001, 32'd1);
        setVec(6, 1, 1, {32'h7FC00001, 224'b0}, 0, 0, 32'h7FC00001, 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].inst, vecs[i].n, vecs[i].ops, vecs[i].maxGap, vecs[i].holdOut,
                          vecs[i].expData, vecs[i].expCount, $sformatf("vec%0d", i));
        end

        resetMidPacket();

        for (int p = 0; p < 24; p++) begin
            ridx = $urandom_range(0, 2);
            rn   = $urandom_range(1, 6);
            sum  = 0.0;
            rops = '0;
            for (int k = 0; k < rn; k++) begin
                rops[k] = realToFp32(real'(int'($urandom_range(0, 32)) - 16) / 2.0);
                sum     = sum + fp32ToReal(rops[k]);
            end
            rexp = (rn == 1) ? rops[0] : realToFp32(sum);
            rsat = satOf(ridx);
            applyStimulus(ridx, rn, rops, $urandom_range(0, 3), $urandom_range(0, 3),
                          rexp, 32'((rn > rsat) ? rsat : rn), $sformatf("rnd%0d", p));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
